// File: rtl/uart_pkg.sv
// Shared UART definitions: default rates, bit-period helpers, state names
// and parity modes used by both the transmitter and the receiver.
package uart_pkg;

  localparam int CLK_FREQ_DEFAULT  = 100_000_000;
  localparam int BAUD_RATE_DEFAULT = 9_600;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  function automatic int calcBitCycles(input int clkFreq, input int baudRate);
    return clkFreq / baudRate;
  endfunction

  // Divider counters never shrink below 14 bits so 9600 baud at 100 MHz fits.
  function automatic int counterWidth(input int divide);
    int w;
    w = $clog2(divide);
    return (w < 14) ? 14 : w;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..DIVIDE-1 while not cleared and flags the last
// count, so a clear on frame start gives an exact first bit period.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIVIDE = 10416
) (
  input  logic clock_fpga,
  input  logic reset,
  input  logic clear_i,
  output logic tick_o
);

  localparam int W = counterWidth(DIVIDE);
  localparam logic [W-1:0] LAST = W'(DIVIDE - 1);

  logic [W-1:0] count_q;

  always_ff @(posedge clock_fpga) begin
    if (reset || clear_i) begin
      count_q <= '0;
    end else if (count_q == LAST) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + W'(1);
    end
  end

  assign tick_o = (count_q == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// 8-bit UART transmitter: valid/ready byte intake, LSB-first framing with
// optional parity and 1 or 2 stop bits; every output comes from a flop.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = CLK_FREQ_DEFAULT,
  parameter int BAUD_RATE  = BAUD_RATE_DEFAULT,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1,
  parameter int BIT_CYCLES = calcBitCycles(CLK_FREQ, BAUD_RATE)
) (
  input  logic       clock_fpga,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       TxD,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic LAST_STOP = (STOP_BITS == 2);

  uart_state_t state_q;
  logic [7:0]  shiftReg_q;
  logic [7:0]  dataByte_q;
  logic [2:0]  bitCnt_q;
  logic        stopCnt_q;
  logic        txd_q;
  logic        ready_q;
  logic        busy_q;
  logic        done_q;

  logic bitTick;
  logic parityBit;

  // Holding the divider clear while idle aligns the start bit to the handshake.
  uart_baud_gen #(
    .DIVIDE(BIT_CYCLES)
  ) baudGen (
    .clock_fpga(clock_fpga),
    .reset     (reset),
    .clear_i   (state_q == ST_IDLE),
    .tick_o    (bitTick)
  );

  assign parityBit = (PARITY == PAR_ODD) ? ~^dataByte_q : ^dataByte_q;

  always_ff @(posedge clock_fpga) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shiftReg_q <= '0;
      dataByte_q <= '0;
      bitCnt_q   <= '0;
      stopCnt_q  <= 1'b0;
      txd_q      <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (tx_valid && ready_q) begin
            shiftReg_q <= tx_data;
            dataByte_q <= tx_data;
            bitCnt_q   <= '0;
            stopCnt_q  <= 1'b0;
            txd_q      <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          if (bitTick) begin
            txd_q   <= shiftReg_q[0];
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bitTick) begin
            bitCnt_q <= bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              if (PARITY != PAR_NONE) begin
                txd_q   <= parityBit;
                state_q <= ST_PARITY;
              end else begin
                txd_q   <= 1'b1;
                state_q <= ST_STOP;
              end
            end else begin
              shiftReg_q <= {1'b0, shiftReg_q[7:1]};
              txd_q      <= shiftReg_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (bitTick) begin
            txd_q   <= 1'b1;
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bitTick) begin
            if (stopCnt_q == LAST_STOP) begin
              stopCnt_q <= 1'b0;
              ready_q   <= 1'b1;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= ST_IDLE;
            end else begin
              stopCnt_q <= 1'b1;
            end
          end
        end
        default: begin
          txd_q   <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign TxD      = txd_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: four instances (no parity, even, odd,
// two stop bits) at 10 clocks per bit, checked cycle by cycle against a frame model.
module tb_uart_transmitter;

  logic       clk;
  logic       reset;
  logic [7:0] txData;
  logic [3:0] valid;
  logic [3:0] ready;
  logic [3:0] txd;
  logic [3:0] busy;
  logic [3:0] done;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 4; g++) begin : gInst
    uart_transmitter #(
      .CLK_FREQ (1_000_000),
      .BAUD_RATE(100_000),
      .PARITY   ((g == 1) ? 1 : ((g == 2) ? 2 : 0)),
      .STOP_BITS((g == 3) ? 2 : 1)
    ) dut (
      .clock_fpga(clk),
      .reset     (reset),
      .tx_data   (txData),
      .tx_valid  (valid[g]),
      .tx_ready  (ready[g]),
      .TxD       (txd[g]),
      .tx_busy   (busy[g]),
      .tx_done   (done[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Expected line level j cycles after the accept edge (j = 1 is the first start-bit cycle).
  function automatic logic expTxd(input logic [7:0] d, input int par, input int j);
    int bitIdx;
    bitIdx = (j - 1) / 10;
    if (bitIdx == 0) return 1'b0;
    if (bitIdx <= 8) return d[bitIdx-1];
    if (bitIdx == 9 && par == 1) return ^d;
    if (bitIdx == 9 && par == 2) return ~^d;
    return 1'b1;
  endfunction

  // Called on a falling edge with the instance idle; returns on j = 1.
  task automatic applyStimulus(input int idx, input logic [7:0] d, input bit hold);
    txData     = d;
    valid[idx] = 1'b1;
    @(negedge clk);
    if (!hold) valid[idx] = 1'b0;
  endtask

  task automatic checkFrame(input int idx, input logic [7:0] d, input int par, input int stops,
                            input int injectAt, input int stopAt);
    int total;
    int last;
    logic eT, eR, eB, eD;
    total = (10 + ((par != 0) ? 1 : 0) + (stops - 1)) * 10;
    last  = (stopAt > 0) ? stopAt : total + 1;
    for (int j = 1; j <= last; j++) begin
      if (j <= total) begin
        eT = expTxd(d, par, j); eR = 1'b0; eB = 1'b1; eD = 1'b0;
      end else begin
        eT = 1'b1; eR = 1'b1; eB = 1'b0; eD = 1'b1;
      end
      checkOutput($sformatf("txd%0d_%h_j%0d", idx, d, j), 8'(txd[idx]), 8'(eT));
      checkOutput($sformatf("ready%0d_%h_j%0d", idx, d, j), 8'(ready[idx]), 8'(eR));
      checkOutput($sformatf("busy%0d_%h_j%0d", idx, d, j), 8'(busy[idx]), 8'(eB));
      checkOutput($sformatf("done%0d_%h_j%0d", idx, d, j), 8'(done[idx]), 8'(eD));
      if (injectAt > 0 && j == injectAt) begin
        txData     = 8'h3C;
        valid[idx] = 1'b1;
      end
      if (injectAt > 0 && j == injectAt + 1) valid[idx] = 1'b0;
      if (j < last) @(negedge clk);
    end
  endtask

  initial begin
    reset  = 1'b1;
    valid  = '0;
    txData = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_txd", 8'(txd), 8'hF);
    checkOutput("rst_ready", 8'(ready), 8'hF);
    checkOutput("rst_busy", 8'(busy), 8'h0);
    checkOutput("rst_done", 8'(done), 8'h0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] single byte 0xA5, no parity");
    applyStimulus(0, 8'hA5, 1'b0);
    checkFrame(0, 8'hA5, 0, 1, 0, 0);

    $display("[TB] parity even/odd with 0x07, two stop bits with 0x96");
    @(negedge clk);
    applyStimulus(1, 8'h07, 1'b0);
    checkFrame(1, 8'h07, 1, 1, 0, 0);
    @(negedge clk);
    applyStimulus(2, 8'h07, 1'b0);
    checkFrame(2, 8'h07, 2, 1, 0, 0);
    @(negedge clk);
    applyStimulus(3, 8'h96, 1'b0);
    checkFrame(3, 8'h96, 0, 2, 0, 0);

    $display("[TB] back-to-back 0x00 then 0xFF");
    @(negedge clk);
    applyStimulus(0, 8'h00, 1'b1);
    txData = 8'hFF;
    checkFrame(0, 8'h00, 0, 1, 0, 0);
    @(negedge clk);
    valid[0] = 1'b0;
    checkFrame(0, 8'hFF, 0, 1, 0, 0);

    $display("[TB] valid pulse while busy is ignored");
    @(negedge clk);
    applyStimulus(0, 8'h81, 1'b0);
    checkFrame(0, 8'h81, 0, 1, 45, 0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      checkOutput($sformatf("idle_txd_%0d", k), 8'(txd[0]), 8'h1);
      checkOutput($sformatf("idle_busy_%0d", k), 8'(busy[0]), 8'h0);
    end

    $display("[TB] reset during data bit 4, valid held with reset");
    applyStimulus(0, 8'hC3, 1'b0);
    checkFrame(0, 8'hC3, 0, 1, 0, 55);
    reset    = 1'b1;
    txData   = 8'hAA;
    valid[0] = 1'b1;
    @(negedge clk);
    checkOutput("midrst_txd", 8'(txd[0]), 8'h1);
    checkOutput("midrst_ready", 8'(ready[0]), 8'h1);
    checkOutput("midrst_busy", 8'(busy[0]), 8'h0);
    checkOutput("midrst_done", 8'(done[0]), 8'h0);
    reset    = 1'b0;
    valid[0] = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      checkOutput($sformatf("postrst_txd_%0d", k), 8'(txd[0]), 8'h1);
      checkOutput($sformatf("postrst_done_%0d", k), 8'(done[0]), 8'h0);
    end
    applyStimulus(0, 8'h55, 1'b0);
    checkFrame(0, 8'h55, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
